issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler_pkg.sv | 34 +++
 rtl/issue_scheduler_sched_scoreboard.sv | 40 ++++
 rtl/issue_scheduler.sv | 160 ++++++++++++++++
 tb/tb_issue_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the in-order 4-slot issue scheduler and its scoreboard.
package issue_scheduler_pkg;

  localparam int unsigned NUM_SLOTS    = 4;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned LAT_W        = 2;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned ALU_LAT_DEF  = 1;
  localparam int unsigned LOAD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PART = 2'd1,
    ST_KILL = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
    logic             branch;
  } slot_t;

  function automatic logic [2:0] popcount4(input logic [NUM_SLOTS-1:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) cnt = cnt + 3'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/issue_scheduler_sched_scoreboard.sv
// Per-register busy counters: loaded with the producer latency on issue,
// decremented each cycle; a register is ready once its counter reaches zero.
module sched_scoreboard
  import issue_scheduler_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SLOTS-1:0]             set_en,
  input  logic [NUM_SLOTS-1:0][REG_W-1:0]  set_rd,
  input  logic [NUM_SLOTS-1:0][LAT_W-1:0]  set_lat,
  output logic [NUM_REGS-1:0]              ready
);

  logic [LAT_W-1:0] busy_q [NUM_REGS];
  logic [LAT_W-1:0] busy_d [NUM_REGS];

  // Decrement first so a same-cycle issue overrides it; younger slots win on rd collisions.
  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - LAT_W'(1) : '0;
    end
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      if (set_en[s] && (set_rd[s] != '0)) busy_d[set_rd[s]] = set_lat[s];
    end
    busy_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_REGS); r++) busy_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) busy_q[r] <= busy_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) ready[r] = (busy_q[r] == '0);
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue of a 4-slot decode group against a latency scoreboard.
// Optional performance counters are built when SCHED_PERF_CNT_EN is defined.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned ALU_LAT  = ALU_LAT_DEF,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        grp_valid,
  input  logic [NUM_SLOTS-1:0]        grp_slot_vld,
  input  logic [NUM_SLOTS*REG_W-1:0]  grp_rs,
  input  logic [NUM_SLOTS*REG_W-1:0]  grp_rt,
  input  logic [NUM_SLOTS*REG_W-1:0]  grp_rd,
  input  logic [NUM_SLOTS-1:0]        grp_wr,
  input  logic [NUM_SLOTS-1:0]        grp_load,
  input  logic [NUM_SLOTS-1:0]        grp_branch,
  input  logic                        flush,
  output logic [NUM_SLOTS-1:0]        issue_mask,
  output logic                        grp_ready
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            issue_cnt
`endif
);

  sched_state_e                     state_q, state_d;
  logic [NUM_SLOTS-1:0]             done_q, done_d;
  slot_t                            slot [NUM_SLOTS];
  logic [NUM_REGS-1:0]              reg_ready;
  logic [NUM_SLOTS-1:0]             issue_c;
  logic [NUM_SLOTS-1:0]             pending;
  logic                             stop;
  logic                             src_ok;
  logic                             raw;
  logic [NUM_SLOTS-1:0]             set_en;
  logic [NUM_SLOTS-1:0][REG_W-1:0]  set_rd;
  logic [NUM_SLOTS-1:0][LAT_W-1:0]  set_lat;

  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      slot[i].rs     = grp_rs[REG_W*i +: REG_W];
      slot[i].rt     = grp_rt[REG_W*i +: REG_W];
      slot[i].rd     = grp_rd[REG_W*i +: REG_W];
      slot[i].wr     = grp_wr[i];
      slot[i].load   = grp_load[i];
      slot[i].branch = grp_branch[i];
    end
  end

  // Walk slots oldest-first; the first blocked slot or an issuing branch ends the run.
  always_comb begin
    issue_c = '0;
    src_ok  = 1'b0;
    raw     = 1'b0;
    stop    = !(rst_n && grp_valid && !flush && (state_q != ST_KILL));
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      src_ok = ((slot[i].rs == '0) || reg_ready[slot[i].rs]) &&
               ((slot[i].rt == '0) || reg_ready[slot[i].rt]);
      raw = 1'b0;
      for (int j = 0; j < int'(NUM_SLOTS); j++) begin
        if ((j < i) && issue_c[j] && slot[j].wr && (slot[j].rd != '0) &&
            ((slot[j].rd == slot[i].rs) || (slot[j].rd == slot[i].rt))) begin
          raw = 1'b1;
        end
      end
      if (!stop && grp_slot_vld[i] && !done_q[i]) begin
        if (src_ok && !raw) begin
          issue_c[i] = 1'b1;
          stop       = slot[i].branch;
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pending    = grp_slot_vld & ~(done_q | issue_c);
    issue_mask = issue_c;
    grp_ready  = rst_n && (flush || (grp_valid && (state_q != ST_KILL) && (pending == '0)));
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      ST_KILL: begin
        state_d = ST_IDLE;
        done_d  = '0;
      end
      default: begin
        if (flush) begin
          state_d = ST_KILL;
          done_d  = '0;
        end else if (grp_valid && grp_ready) begin
          state_d = ST_IDLE;
          done_d  = '0;
        end else if (issue_c != '0) begin
          state_d = ST_PART;
          done_d  = done_q | issue_c;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      set_en[i]  = issue_c[i] & slot[i].wr;
      set_rd[i]  = slot[i].rd;
      set_lat[i] = slot[i].load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
    end
  end

  sched_scoreboard u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (set_en),
    .set_rd  (set_rd),
    .set_lat (set_lat),
    .ready   (reg_ready)
  );

`ifdef SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + CNT_W'(popcount4(issue_c));
    stall_cnt_d = stall_cnt_q;
    if (grp_valid && !flush && (issue_c == '0)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       grp_valid;
  logic [NUM_SLOTS-1:0]       grp_slot_vld;
  logic [NUM_SLOTS*REG_W-1:0] grp_rs, grp_rt, grp_rd;
  logic [NUM_SLOTS-1:0]       grp_wr, grp_load, grp_branch;
  logic                       flush;
  logic [NUM_SLOTS-1:0]       issue_mask;
  logic                       grp_ready;
`ifdef SCHED_PERF_CNT_EN
  logic [CNT_W-1:0]           stall_cnt, issue_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .grp_valid    (grp_valid),
    .grp_slot_vld (grp_slot_vld),
    .grp_rs       (grp_rs),
    .grp_rt       (grp_rt),
    .grp_rd       (grp_rd),
    .grp_wr       (grp_wr),
    .grp_load     (grp_load),
    .grp_branch   (grp_branch),
    .flush        (flush),
    .issue_mask   (issue_mask),
    .grp_ready    (grp_ready)
`ifdef SCHED_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .issue_cnt    (issue_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_grp();
    grp_slot_vld = '0;
    grp_rs       = '0;
    grp_rt       = '0;
    grp_rd       = '0;
    grp_wr       = '0;
    grp_load     = '0;
    grp_branch   = '0;
  endtask

  task automatic set_slot(input int s, input logic [4:0] rd, input logic [4:0] rs,
                          input logic [4:0] rt, input logic wr, input logic ld, input logic br);
    grp_slot_vld[s]     = 1'b1;
    grp_rd[5*s +: 5]    = rd;
    grp_rs[5*s +: 5]    = rs;
    grp_rt[5*s +: 5]    = rt;
    grp_wr[s]           = wr;
    grp_load[s]         = ld;
    grp_branch[s]       = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string tag, input logic [3:0] exp_mask, input logic exp_rdy);
    @(negedge clk);
    check_eq({tag, "_mask"}, 32'(issue_mask), 32'(exp_mask));
    check_eq({tag, "_rdy"}, 32'(grp_ready), 32'(exp_rdy));
  endtask

  task automatic idle(input int n);
    grp_valid = 1'b0;
    clear_grp();
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    grp_valid = 1'b1;
    clear_grp();
    set_slot(0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);

    // Reset holds outputs low even with a ready group offered
    sample("reset", 4'b0000, 1'b0);
    step();
    sample("reset2", 4'b0000, 1'b0);
`ifdef SCHED_PERF_CNT_EN
    check_eq("reset_issue_cnt", issue_cnt, 32'd0);
    check_eq("reset_stall_cnt", stall_cnt, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    idle(1);

    // Four independent ALU ops
    grp_valid = 1'b1;
    clear_grp();
    set_slot(0, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0);
    set_slot(1, 5'd4,  5'd5,  5'd6,  1'b1, 1'b0, 1'b0);
    set_slot(2, 5'd7,  5'd8,  5'd9,  1'b1, 1'b0, 1'b0);
    set_slot(3, 5'd10, 5'd11, 5'd12, 1'b1, 1'b0, 1'b0);
    sample("indep", 4'b1111, 1'b1);
    step();
    grp_valid = 1'b0;
    clear_grp();
    sample("novalid", 4'b0000, 1'b0);
    idle(2);

    // Load-use: slot1 waits for LOAD_LAT; invalid slot2 with conflicting fields is ignored
    grp_valid = 1'b1;
    set_slot(0, 5'd5, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    set_slot(1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
    set_slot(2, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
    grp_slot_vld[2] = 1'b0;
    sample("ld_c0", 4'b0001, 1'b0);
    step();
    sample("ld_c1", 4'b0000, 1'b0);
    step();
    sample("ld_c2", 4'b0000, 1'b0);
    step();
    sample("ld_c3", 4'b0010, 1'b1);
    step();
    idle(2);

    // One branch per cycle
    grp_valid = 1'b1;
    set_slot(0, 5'd13, 5'd14, 5'd0,  1'b1, 1'b0, 1'b0);
    set_slot(1, 5'd0,  5'd15, 5'd16, 1'b0, 1'b0, 1'b1);
    set_slot(2, 5'd17, 5'd18, 5'd0,  1'b1, 1'b0, 1'b0);
    set_slot(3, 5'd19, 5'd20, 5'd0,  1'b1, 1'b0, 1'b0);
    sample("br_c0", 4'b0011, 1'b0);
    step();
    sample("br_c1", 4'b1100, 1'b1);
    step();
    idle(2);

    // rd=$0 creates no hazard, invalid slot1 skipped, slot3 RAW on slot2
    grp_valid = 1'b1;
    set_slot(0, 5'd0,  5'd21, 5'd0,  1'b1, 1'b0, 1'b0);
    set_slot(2, 5'd22, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0);
    set_slot(3, 5'd29, 5'd22, 5'd0,  1'b1, 1'b0, 1'b0);
    sample("raw_c0", 4'b0101, 1'b0);
    step();
    sample("raw_c1", 4'b0000, 1'b0);
    step();
    sample("raw_c2", 4'b1000, 1'b1);
    step();
    idle(2);

    // Flush while partly issued, then KILL, then a fresh group
    grp_valid = 1'b1;
    set_slot(0, 5'd23, 5'd0,  5'd0, 1'b1, 1'b1, 1'b0);
    set_slot(1, 5'd28, 5'd23, 5'd0, 1'b1, 1'b0, 1'b0);
    sample("fl_c0", 4'b0001, 1'b0);
    step();
    flush = 1'b1;
    sample("fl_flush", 4'b0000, 1'b1);
    step();
    flush = 1'b0;
    clear_grp();
    set_slot(0, 5'd24, 5'd25, 5'd0, 1'b1, 1'b0, 1'b0);
    set_slot(1, 5'd26, 5'd27, 5'd0, 1'b1, 1'b0, 1'b0);
    sample("fl_kill", 4'b0000, 1'b0);
    step();
    sample("fl_new", 4'b0011, 1'b1);
    step();
    idle(3);

    // Reset pulse mid-group clears the busy counter on $7
    grp_valid = 1'b1;
    set_slot(0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    set_slot(1, 5'd9, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
    sample("rst_c0", 4'b0001, 1'b0);
    step();
    rst_n = 1'b0;
    sample("rst_in", 4'b0000, 1'b0);
    step();
    rst_n = 1'b1;
    clear_grp();
    set_slot(0, 5'd8, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
`ifdef SCHED_PERF_CNT_EN
    check_eq("rst_issue_cnt", issue_cnt, 32'd0);
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    sample("rst_after", 4'b0001, 1'b1);
    step();
    grp_valid = 1'b0;
    clear_grp();
`ifdef SCHED_PERF_CNT_EN
    check_eq("post_issue_cnt", issue_cnt, 32'd1);
    check_eq("post_stall_cnt", stall_cnt, 32'd0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
